// File: rtl/gemm_job_scheduler.sv
// Round-robin scheduler sharing one tiled GeMM accelerator between NumReq requesters:
// grants in IDLE (combinational ready), validates sizes, relocates addresses, reports completion.
module gemm_job_scheduler #(
  parameter int NumReq        = 2,
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16,
  parameter int TileM         = 4,
  parameter int TileK         = 4,
  parameter int TileN         = 4,
  parameter int CycleWidth    = 16,
  localparam int IdWidth      = $clog2(NumReq)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq*SizeAddrWidth-1:0] req_m_size_i,
  input  logic [NumReq*SizeAddrWidth-1:0] req_k_size_i,
  input  logic [NumReq*SizeAddrWidth-1:0] req_n_size_i,
  input  logic [NumReq*AddrWidth-1:0]     req_a_base_i,
  input  logic [NumReq*AddrWidth-1:0]     req_b_base_i,
  input  logic [NumReq*AddrWidth-1:0]     req_c_base_i,
  output logic [NumReq-1:0]               rsp_valid_o,
  input  logic [NumReq-1:0]               rsp_ready_i,
  output logic [NumReq-1:0]               rsp_err_o,
  output logic [NumReq*CycleWidth-1:0]    rsp_cycles_o,
  output logic                            acc_start_o,
  output logic [SizeAddrWidth-1:0]        acc_m_size_o,
  output logic [SizeAddrWidth-1:0]        acc_k_size_o,
  output logic [SizeAddrWidth-1:0]        acc_n_size_o,
  input  logic                            acc_done_i,
  input  logic [AddrWidth-1:0]            acc_a_addr_i,
  input  logic [AddrWidth-1:0]            acc_b_addr_i,
  input  logic [AddrWidth-1:0]            acc_c_addr_i,
  output logic [AddrWidth-1:0]            sram_a_addr_o,
  output logic [AddrWidth-1:0]            sram_b_addr_o,
  output logic [AddrWidth-1:0]            sram_c_addr_o,
  output logic                            busy_o,
  output logic [IdWidth-1:0]              grant_id_o
);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t                       state;
  logic [IdWidth-1:0]           last_grant;
  logic [IdWidth-1:0]           grant_id;
  logic [NumReq-1:0]            rsp_valid;
  logic [NumReq-1:0]            rsp_err;
  logic [NumReq*CycleWidth-1:0] rsp_cycles;
  logic [CycleWidth-1:0]        counter;
  logic [CycleWidth-1:0]        cycles_next;
  logic [AddrWidth-1:0]         a_base, b_base, c_base;
  logic [SizeAddrWidth-1:0]     m_size, k_size, n_size;
  logic                         acc_start;

  logic [NumReq-1:0]            eligible;
  logic [NumReq-1:0]            pick;
  logic [IdWidth-1:0]           pick_id;
  logic [IdWidth-1:0]           cand;
  logic                         pick_any;
  logic [SizeAddrWidth-1:0]     m_in, k_in, n_in;
  logic                         sizes_ok;

  // A requester with an unconsumed completion is held off until it is drained.
  assign eligible = req_valid_i & ~rsp_valid;

  always_comb begin
    pick     = '0;
    pick_id  = '0;
    pick_any = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = IdWidth'((int'(last_grant) + i) % NumReq);
      if (!pick_any && eligible[cand]) begin
        pick_any = 1'b1;
        pick_id  = cand;
      end
    end
    if (state == IDLE && pick_any) pick[pick_id] = 1'b1;
  end

  assign m_in = req_m_size_i[pick_id*SizeAddrWidth +: SizeAddrWidth];
  assign k_in = req_k_size_i[pick_id*SizeAddrWidth +: SizeAddrWidth];
  assign n_in = req_n_size_i[pick_id*SizeAddrWidth +: SizeAddrWidth];

  assign sizes_ok = (m_in != '0) && (k_in != '0) && (n_in != '0) &&
                    ((m_in % SizeAddrWidth'(TileM)) == '0) &&
                    ((k_in % SizeAddrWidth'(TileK)) == '0) &&
                    ((n_in % SizeAddrWidth'(TileN)) == '0);

  // Reported count includes the done cycle; saturates rather than wrapping.
  assign cycles_next = (counter == '1) ? counter : counter + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last_grant <= IdWidth'(NumReq - 1);
      grant_id   <= '0;
      rsp_valid  <= '0;
      rsp_err    <= '0;
      rsp_cycles <= '0;
      counter    <= '0;
      a_base     <= '0;
      b_base     <= '0;
      c_base     <= '0;
      m_size     <= '0;
      k_size     <= '0;
      n_size     <= '0;
      acc_start  <= 1'b0;
    end else begin
      acc_start <= 1'b0;
      for (int r = 0; r < NumReq; r++) begin
        if (rsp_valid[r] && rsp_ready_i[r]) rsp_valid[r] <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id   <= pick_id;
            last_grant <= pick_id;
            m_size     <= m_in;
            k_size     <= k_in;
            n_size     <= n_in;
            a_base     <= req_a_base_i[pick_id*AddrWidth +: AddrWidth];
            b_base     <= req_b_base_i[pick_id*AddrWidth +: AddrWidth];
            c_base     <= req_c_base_i[pick_id*AddrWidth +: AddrWidth];
            if (sizes_ok) begin
              state     <= START;
              acc_start <= 1'b1;
            end else begin
              state <= RESP;
            end
          end
        end
        START: begin
          counter <= '0;
          state   <= RUN;
        end
        RUN: begin
          counter <= cycles_next;
          if (acc_done_i) begin
            rsp_valid[grant_id]                               <= 1'b1;
            rsp_err[grant_id]                                 <= 1'b0;
            rsp_cycles[grant_id*CycleWidth +: CycleWidth]     <= cycles_next;
            state                                             <= IDLE;
          end
        end
        RESP: begin
          rsp_valid[grant_id]                           <= 1'b1;
          rsp_err[grant_id]                             <= 1'b1;
          rsp_cycles[grant_id*CycleWidth +: CycleWidth] <= '0;
          state                                         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = pick;
  assign rsp_valid_o   = rsp_valid;
  assign rsp_err_o     = rsp_err;
  assign rsp_cycles_o  = rsp_cycles;
  assign acc_start_o   = acc_start;
  assign acc_m_size_o  = m_size;
  assign acc_k_size_o  = k_size;
  assign acc_n_size_o  = n_size;
  assign sram_a_addr_o = acc_a_addr_i + a_base;
  assign sram_b_addr_o = acc_b_addr_i + b_base;
  assign sram_c_addr_o = acc_c_addr_i + c_base;
  assign busy_o        = (state != IDLE);
  assign grant_id_o    = grant_id;

endmodule
